// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 sequencing controller.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int INIT_CYCLES = 128;
    localparam int SBOX_SIZE   = 256;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA_RD,
        KSA_SW,
        PG_RD,
        PG_SW,
        PG_OUT,
        PG_VALID
    } state_t;

endpackage

// File: rtl/rc4_key_regs.sv
// Key register file with effective-length clamp and a wrapping key index
// that walks 0..L-1 during key scheduling.
module rc4_key_regs
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [$clog2(KEY_BYTES)-1:0] widx,
    input  logic [7:0]                   wdata,
    input  logic [7:0]                   key_len,
    input  logic                         kidx_clr,
    input  logic                         kidx_adv,
    output logic [7:0]                   key_byte
);

    localparam int IW = $clog2(KEY_BYTES);

    byte_t         key_q [KEY_BYTES];
    logic [IW-1:0] kidx_q;
    logic [8:0]    eff_len;
    logic          kidx_last;

    // A zero or oversized length selects the full register file.
    always_comb begin
        eff_len = {1'b0, key_len};
        if (key_len == 8'd0 || {1'b0, key_len} > 9'(KEY_BYTES)) begin
            eff_len = 9'(KEY_BYTES);
        end
    end

    assign kidx_last = ({{(9 - IW){1'b0}}, kidx_q} == eff_len - 9'd1);
    assign key_byte  = key_q[kidx_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < KEY_BYTES; k++) begin
                key_q[k] <= '0;
            end
        end else if (we && int'(widx) < KEY_BYTES) begin
            key_q[widx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || kidx_clr) begin
            kidx_q <= '0;
        end else if (kidx_adv) begin
            kidx_q <= kidx_last ? '0 : kidx_q + IW'(1);
        end
    end

endmodule

// File: rtl/rc4_ctrl.sv
// RC4 sequencer: fills the state RAM, runs key scheduling, then streams
// keystream bytes over a valid/ready handshake.
module rc4_ctrl
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_we,
    input  logic [$clog2(KEY_BYTES)-1:0] key_idx,
    input  logic [7:0]                   key_data,
    input  logic [7:0]                   key_len,
    input  logic                         start,
    input  logic                         stop,
    output logic                         busy,
    output logic [7:0]                   ks_data,
    output logic                         ks_valid,
    input  logic                         ks_ready,
    output logic                         ram_wen,
    output logic [7:0]                   ram_raddr_1,
    output logic [7:0]                   ram_waddr_2,
    output logic [7:0]                   ram_wdata_2,
    output logic [7:0]                   ram_addr_3,
    output logic [7:0]                   ram_wdata_3,
    input  logic [7:0]                   ram_rdata_1,
    input  logic [7:0]                   ram_rdata_3
);

    state_t     state_q, state_d;
    byte_t      i_q, j_q, si_q, t_q, ks_data_q;
    logic [6:0] c_q;
    logic       ks_valid_q;
    logic       kidx_clr, kidx_adv;
    byte_t      key_byte;

    localparam logic [6:0] C_LAST = 7'(INIT_CYCLES - 1);
    localparam byte_t      I_LAST = 8'(SBOX_SIZE - 1);

    rc4_key_regs #(.KEY_BYTES(KEY_BYTES)) u_key_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (key_we && state_q == IDLE),
        .widx     (key_idx),
        .wdata    (key_data),
        .key_len  (key_len),
        .kidx_clr (kidx_clr),
        .kidx_adv (kidx_adv),
        .key_byte (key_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ram_wen     = 1'b0;
        ram_raddr_1 = '0;
        ram_waddr_2 = '0;
        ram_wdata_2 = '0;
        ram_addr_3  = '0;
        ram_wdata_3 = '0;
        kidx_clr    = 1'b0;
        kidx_adv    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                // Two identity entries per cycle: even via port 2, odd via port 3.
                ram_wen     = 1'b1;
                ram_waddr_2 = {c_q, 1'b0};
                ram_wdata_2 = {c_q, 1'b0};
                ram_addr_3  = {c_q, 1'b1};
                ram_wdata_3 = {c_q, 1'b1};
                if (c_q == C_LAST) begin
                    state_d  = KSA_RD;
                    kidx_clr = 1'b1;
                end
            end
            KSA_RD: begin
                ram_addr_3 = i_q;
                state_d    = KSA_SW;
            end
            KSA_SW: begin
                ram_raddr_1 = j_q;
                ram_wen     = 1'b1;
                ram_waddr_2 = i_q;
                ram_wdata_2 = ram_rdata_1;
                ram_addr_3  = j_q;
                ram_wdata_3 = si_q;
                kidx_adv    = 1'b1;
                state_d     = (i_q == I_LAST) ? PG_RD : KSA_RD;
            end
            PG_RD: begin
                ram_addr_3 = i_q + 8'd1;
                state_d    = PG_SW;
            end
            PG_SW: begin
                ram_raddr_1 = j_q;
                ram_wen     = 1'b1;
                ram_waddr_2 = i_q;
                ram_wdata_2 = ram_rdata_1;
                ram_addr_3  = j_q;
                ram_wdata_3 = si_q;
                state_d     = PG_OUT;
            end
            PG_OUT: begin
                // Read after the swap has committed.
                ram_raddr_1 = t_q;
                state_d     = PG_VALID;
            end
            PG_VALID: begin
                if (ks_ready) state_d = PG_RD;
            end
            default: state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q        <= '0;
            j_q        <= '0;
            si_q       <= '0;
            t_q        <= '0;
            c_q        <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        i_q <= '0;
                        c_q <= '0;
                    end
                end
                INIT: begin
                    c_q <= c_q + 7'd1;
                    if (c_q == C_LAST) begin
                        i_q <= '0;
                        j_q <= '0;
                    end
                end
                KSA_RD: begin
                    si_q <= ram_rdata_3;
                    j_q  <= j_q + ram_rdata_3 + key_byte;
                end
                KSA_SW: begin
                    i_q <= i_q + 8'd1;
                    if (i_q == I_LAST) j_q <= '0;
                end
                PG_RD: begin
                    i_q  <= i_q + 8'd1;
                    si_q <= ram_rdata_3;
                    j_q  <= j_q + ram_rdata_3;
                end
                PG_SW: begin
                    t_q <= si_q + ram_rdata_1;
                end
                PG_OUT: begin
                    ks_data_q  <= ram_rdata_1;
                    ks_valid_q <= 1'b1;
                end
                PG_VALID: begin
                    if (ks_ready) ks_valid_q <= 1'b0;
                end
                default: ;
            endcase
            if (stop) ks_valid_q <= 1'b0;
        end
    end

    assign busy     = (state_q != IDLE);
    assign ks_data  = ks_data_q;
    assign ks_valid = ks_valid_q;

endmodule
